// File: rtl/smc_mem_resp_lite.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : smc_mem_resp_lite                                          |
// | Description : Memory-side responder for a static-memory-controller bus.  |
// |               Samples active-low CS/OE/WE strobes on sys_clk, services   |
// |               reads after RD_LAT cycles and commits writes once WE has   |
// |               been held low for at least WR_MIN cycles. Protocol          |
// |               violations raise a single-cycle timing_err pulse.          |
// | Config      : define SMC_RESP_ERRCNT_EN to build the saturating 8-bit    |
// |               timing-error counter on err_count; otherwise err_count is  |
// |               tied to zero.                                              |
// | Ports       : sys_clk, n_sys_reset (async, active low)                   |
// |               smc_n_cs/smc_n_oe/smc_n_we, smc_addr, smc_data  (inputs)   |
// |               mem_data, mem_data_oe          read data and drive enable  |
// |               rd_done, wr_done, timing_err   registered 1-cycle pulses   |
// |               resp_state                     registered FSM state        |
// |               err_count                      timing-error count          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module smc_mem_resp_lite #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2,
    parameter int WR_MIN = 1
) (
    input  logic              sys_clk,
    input  logic              n_sys_reset,
    input  logic              smc_n_cs,
    input  logic              smc_n_oe,
    input  logic              smc_n_we,
    input  logic [ADDR_W-1:0] smc_addr,
    input  logic [DATA_W-1:0] smc_data,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_data_oe,
    output logic              rd_done,
    output logic              wr_done,
    output logic              timing_err,
    output logic [2:0]        resp_state,
    output logic [7:0]        err_count
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_SELECT    = 3'd1;
    localparam logic [2:0] c_RD_WAIT   = 3'd2;
    localparam logic [2:0] c_RD_DRIVE  = 3'd3;
    localparam logic [2:0] c_WR_ACTIVE = 3'd4;

    localparam int         c_DEPTH     = 2 ** ADDR_W;
    // Counters are loaded with latency-1 because the loading edge itself
    // counts as the first cycle of the wait.
    localparam logic [3:0] c_RD_LOAD   = 4'(RD_LAT - 1);
    localparam logic [3:0] c_WR_LOAD   = 4'(WR_MIN - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr_q;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_mem_data;
    logic              r_rd_done;
    logic              r_wr_done;
    logic              r_timing_err;
    logic [DATA_W-1:0] r_mem [c_DEPTH];

    logic              w_rd_break;
    logic              w_wr_end;
    logic              w_addr_chg;
    logic [2:0]        w_ret;
    logic              w_terr;
    logic              w_rd_done;
    logic              w_wr_commit;
    logic              w_ld_rd;
    logic              w_ld_wr;
    logic              w_rd_fire;
    logic              w_cnt_dec;
    logic              w_wcap;

    assign w_rd_break = smc_n_oe | smc_n_cs;
    assign w_wr_end   = smc_n_we | smc_n_cs;
    assign w_addr_chg = (smc_addr != r_addr_q);
    // Ending an access returns to SELECT while the chip is still selected.
    assign w_ret      = smc_n_cs ? c_IDLE : c_SELECT;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge n_sys_reset) begin
        if (!n_sys_reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (!smc_n_cs) w_state_nxt = c_SELECT;
            end
            c_SELECT: begin
                if (smc_n_cs)                     w_state_nxt = c_IDLE;
                else if (!smc_n_oe && !smc_n_we)  w_state_nxt = c_SELECT;
                else if (!smc_n_oe)               w_state_nxt = c_RD_WAIT;
                else if (!smc_n_we)               w_state_nxt = c_WR_ACTIVE;
                else                              w_state_nxt = c_SELECT;
            end
            c_RD_WAIT: begin
                if (w_rd_break)       w_state_nxt = w_ret;
                else if (r_cnt == 0)  w_state_nxt = c_RD_DRIVE;
            end
            c_RD_DRIVE: begin
                if (w_rd_break)       w_state_nxt = w_ret;
                else if (w_addr_chg)  w_state_nxt = c_RD_WAIT;
            end
            c_WR_ACTIVE: begin
                if (w_wr_end)         w_state_nxt = w_ret;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_terr      = 1'b0;
        w_rd_done   = 1'b0;
        w_wr_commit = 1'b0;
        w_ld_rd     = 1'b0;
        w_ld_wr     = 1'b0;
        w_rd_fire   = 1'b0;
        w_cnt_dec   = 1'b0;
        w_wcap      = 1'b0;
        case (r_state)
            c_SELECT: begin
                if (!smc_n_cs) begin
                    if (!smc_n_oe && !smc_n_we) begin
                        w_terr = 1'b1;
                    end else if (!smc_n_oe) begin
                        w_ld_rd = 1'b1;
                    end else if (!smc_n_we) begin
                        w_ld_wr = 1'b1;
                        w_wcap  = 1'b1;
                    end
                end
            end
            c_RD_WAIT: begin
                // Strobe release takes priority over the final wait cycle so
                // data is never driven to a controller that has gone away.
                if (w_rd_break)       w_terr    = 1'b1;
                else if (r_cnt == 0)  w_rd_fire = 1'b1;
                else                  w_cnt_dec = 1'b1;
            end
            c_RD_DRIVE: begin
                if (w_rd_break)       w_rd_done = 1'b1;
                else if (w_addr_chg)  w_ld_rd   = 1'b1;
            end
            c_WR_ACTIVE: begin
                if (!smc_n_oe) w_terr = 1'b1;
                if (w_wr_end) begin
                    if (r_cnt == 0) w_wr_commit = 1'b1;
                    else            w_terr      = 1'b1;
                end else begin
                    w_wcap = 1'b1;
                    if (r_cnt != 0) w_cnt_dec = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and pulse registers
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge n_sys_reset) begin
        if (!n_sys_reset) begin
            r_cnt        <= 4'd0;
            r_addr_q     <= '0;
            r_wdata      <= '0;
            r_mem_data   <= '0;
            r_rd_done    <= 1'b0;
            r_wr_done    <= 1'b0;
            r_timing_err <= 1'b0;
        end else begin
            r_rd_done    <= w_rd_done;
            r_wr_done    <= w_wr_commit;
            r_timing_err <= w_terr;

            if (w_ld_rd || w_ld_wr) r_addr_q <= smc_addr;

            if (w_ld_rd)        r_cnt <= c_RD_LOAD;
            else if (w_ld_wr)   r_cnt <= c_WR_LOAD;
            else if (w_cnt_dec) r_cnt <= r_cnt - 4'd1;

            if (w_wcap)    r_wdata    <= smc_data;
            if (w_rd_fire) r_mem_data <= r_mem[r_addr_q];
        end
    end

    // Storage array deliberately has no reset; contents survive n_sys_reset.
    // A write can only be committed from WR_ACTIVE, so a reset mid-write
    // (which forces IDLE) discards it.
    always_ff @(posedge sys_clk) begin
        if (w_wr_commit) r_mem[r_addr_q] <= r_wdata;
    end

`ifdef SMC_RESP_ERRCNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge sys_clk or negedge n_sys_reset) begin
        if (!n_sys_reset) begin
            r_err_count <= 8'd0;
        end else if (w_terr && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = 8'd0;
`endif

    assign mem_data    = r_mem_data;
    assign mem_data_oe = (r_state == c_RD_DRIVE);
    assign rd_done     = r_rd_done;
    assign wr_done     = r_wr_done;
    assign timing_err  = r_timing_err;
    assign resp_state  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_smc_mem_resp_lite.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_smc_mem_resp_lite                                       |
// | Description : Self-checking bench for smc_mem_resp_lite. Two instances   |
// |               (default timing and RD_LAT=3/WR_MIN=3) are exercised by    |
// |               transaction tasks; expectations come from a memory model   |
// |               and the protocol timing rules.                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_smc_mem_resp_lite;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int LAT0 = 2, WMIN0 = 1, LAT1 = 3, WMIN1 = 3;

    logic              sys_clk = 1'b0;
    logic              n_sys_reset;
    logic              smc_n_cs   [2];
    logic              smc_n_oe   [2];
    logic              smc_n_we   [2];
    logic [ADDR_W-1:0] smc_addr   [2];
    logic [DATA_W-1:0] smc_data   [2];
    logic [DATA_W-1:0] mem_data   [2];
    logic              mem_data_oe[2];
    logic              rd_done    [2];
    logic              wr_done    [2];
    logic              timing_err [2];
    logic [2:0]        resp_state [2];
    logic [7:0]        err_count  [2];

    always #5 sys_clk = ~sys_clk;

    smc_mem_resp_lite #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(LAT0), .WR_MIN(WMIN0)) u_dut0 (
        .sys_clk(sys_clk), .n_sys_reset(n_sys_reset),
        .smc_n_cs(smc_n_cs[0]), .smc_n_oe(smc_n_oe[0]), .smc_n_we(smc_n_we[0]),
        .smc_addr(smc_addr[0]), .smc_data(smc_data[0]),
        .mem_data(mem_data[0]), .mem_data_oe(mem_data_oe[0]),
        .rd_done(rd_done[0]), .wr_done(wr_done[0]), .timing_err(timing_err[0]),
        .resp_state(resp_state[0]), .err_count(err_count[0])
    );

    smc_mem_resp_lite #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(LAT1), .WR_MIN(WMIN1)) u_dut1 (
        .sys_clk(sys_clk), .n_sys_reset(n_sys_reset),
        .smc_n_cs(smc_n_cs[1]), .smc_n_oe(smc_n_oe[1]), .smc_n_we(smc_n_we[1]),
        .smc_addr(smc_addr[1]), .smc_data(smc_data[1]),
        .mem_data(mem_data[1]), .mem_data_oe(mem_data_oe[1]),
        .rd_done(rd_done[1]), .wr_done(wr_done[1]), .timing_err(timing_err[1]),
        .resp_state(resp_state[1]), .err_count(err_count[1])
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int lat  [2];
    int wmin [2];

    // Reference model: memory image plus running expected timing-error total.
    logic [DATA_W-1:0] ref_mem [2][16];
    bit                ref_vld [2][16];
    int                tot_terr[2];

    // Observed activity since the start of the current transaction.
    int                n_rd[2], n_wr[2], n_terr[2], n_oe_cyc[2], n_rise[2];
    logic              prev_oe[2];
    logic [DATA_W-1:0] rdat[2][4];
    int                rcyc[2][4];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_errcnt(input int d);
        int v;
        v = (tot_terr[d] > 255) ? 255 : tot_terr[d];
`ifndef SMC_RESP_ERRCNT_EN
        v = 0;
`endif
        return v;
    endfunction

    // One clock: inputs already set, observe #1 after the rising edge.
    task automatic step();
        @(posedge sys_clk);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (rd_done[d])    n_rd[d]++;
            if (wr_done[d])    n_wr[d]++;
            if (timing_err[d]) n_terr[d]++;
            if (mem_data_oe[d]) begin
                n_oe_cyc[d]++;
                if (!prev_oe[d]) begin
                    if (n_rise[d] < 4) begin
                        rdat[d][n_rise[d]] = mem_data[d];
                        rcyc[d][n_rise[d]] = cyc;
                    end
                    n_rise[d]++;
                end
            end
            prev_oe[d] = mem_data_oe[d];
        end
    endtask

    task automatic clear_mon(input int d);
        n_rd[d] = 0; n_wr[d] = 0; n_terr[d] = 0; n_oe_cyc[d] = 0; n_rise[d] = 0;
    endtask

    task automatic idle_bus(input int d);
        smc_n_cs[d] = 1'b1; smc_n_oe[d] = 1'b1; smc_n_we[d] = 1'b1;
    endtask

    // Write: WE low for nlow samples; data may change each cycle and the value
    // present at the last WE-low sample is the one stored.
    task automatic do_write(input int d, input int a, input int nlow, input bit oe_abuse,
                            input logic [DATA_W-1:0] fix_data, input bit rnd);
        logic [DATA_W-1:0] last;
        bit commit;
        int exp_terr;
        clear_mon(d);
        smc_n_cs[d] = 1'b0; step();
        check_eq("wr_sel_state", resp_state[d], 1);
        smc_addr[d] = ADDR_W'(a);
        smc_n_we[d] = 1'b0;
        last = '0;
        for (int i = 0; i < nlow; i++) begin
            smc_data[d] = rnd ? DATA_W'($urandom) : fix_data;
            last        = smc_data[d];
            smc_n_oe[d] = (oe_abuse && i > 0) ? 1'b0 : 1'b1;
            step();
            if (i == 0) check_eq("wr_state", resp_state[d], 4);
            smc_addr[d] = ADDR_W'($urandom);
        end
        smc_n_we[d] = 1'b1; smc_n_oe[d] = 1'b1; step();
        smc_n_cs[d] = 1'b1; step(); step();
        commit   = (nlow >= wmin[d]);
        exp_terr = (oe_abuse ? nlow - 1 : 0) + (commit ? 0 : 1);
        if (commit) begin
            ref_mem[d][a] = last;
            ref_vld[d][a] = 1'b1;
        end
        tot_terr[d] += exp_terr;
        check_eq("wr_done_cnt", n_wr[d], commit ? 1 : 0);
        check_eq("wr_terr_cnt", n_terr[d], exp_terr);
        check_eq("wr_err_count", err_count[d], exp_errcnt(d));
    endtask

    // Read: OE low for nhold samples. Data is driven only if OE stays low
    // through RD_LAT samples after the first one.
    task automatic do_read(input int d, input int a, input int nhold);
        int e0;
        bit ok;
        clear_mon(d);
        ok = (nhold >= lat[d] + 1);
        smc_n_cs[d] = 1'b0; step();
        smc_addr[d] = ADDR_W'(a); smc_n_oe[d] = 1'b0; step();
        e0 = cyc;
        check_eq("rd_wait_state", resp_state[d], 2);
        for (int i = 1; i < nhold; i++) step();
        smc_n_oe[d] = 1'b1; step();
        smc_n_cs[d] = 1'b1; step(); step();
        if (!ok) tot_terr[d]++;
        check_eq("rd_done_cnt", n_rd[d], ok ? 1 : 0);
        check_eq("rd_terr_cnt", n_terr[d], ok ? 0 : 1);
        check_eq("rd_oe_cycles", n_oe_cyc[d], ok ? nhold - lat[d] : 0);
        if (ok) begin
            check_eq("rd_latency", rcyc[d][0] - e0, lat[d]);
            if (ref_vld[d][a]) check_eq("rd_data", rdat[d][0], ref_mem[d][a]);
        end
        check_eq("rd_err_count", err_count[d], exp_errcnt(d));
    endtask

    // Back-to-back read: address changes under a continuously low OE.
    task automatic do_read2(input int d, input int a1, input int a2, input int h1, input int h2);
        int e0, e1;
        clear_mon(d);
        smc_n_cs[d] = 1'b0; step();
        smc_addr[d] = ADDR_W'(a1); smc_n_oe[d] = 1'b0; step();
        e0 = cyc;
        for (int i = 1; i < h1; i++) step();
        smc_addr[d] = ADDR_W'(a2); step();
        e1 = cyc;
        for (int i = 1; i < h2; i++) step();
        smc_n_oe[d] = 1'b1; step();
        smc_n_cs[d] = 1'b1; step(); step();
        check_eq("rd2_rises", n_rise[d], 2);
        check_eq("rd2_lat1", rcyc[d][0] - e0, lat[d]);
        check_eq("rd2_lat2", rcyc[d][1] - e1, lat[d]);
        check_eq("rd2_data1", rdat[d][0], ref_mem[d][a1]);
        check_eq("rd2_data2", rdat[d][1], ref_mem[d][a2]);
        check_eq("rd2_oe_cycles", n_oe_cyc[d], (h1 - lat[d]) + (h2 - lat[d]));
        check_eq("rd2_done_cnt", n_rd[d], 1);
        check_eq("rd2_terr_cnt", n_terr[d], 0);
    endtask

    // OE and WE both low while selected: one error per cycle.
    task automatic do_conflict(input int d, input int n);
        clear_mon(d);
        smc_n_cs[d] = 1'b0; step();
        smc_n_oe[d] = 1'b0; smc_n_we[d] = 1'b0;
        for (int i = 0; i < n; i++) step();
        check_eq("cf_state", resp_state[d], 1);
        smc_n_oe[d] = 1'b1; smc_n_we[d] = 1'b1; step();
        smc_n_cs[d] = 1'b1; step(); step();
        tot_terr[d] += n;
        check_eq("cf_terr_cnt", n_terr[d], n);
        check_eq("cf_rdwr_cnt", n_rd[d] + n_wr[d], 0);
        check_eq("cf_err_count", err_count[d], exp_errcnt(d));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        lat[0] = LAT0;  lat[1] = LAT1;
        wmin[0] = WMIN0; wmin[1] = WMIN1;
        for (int d = 0; d < 2; d++) begin
            idle_bus(d);
            smc_addr[d] = '0; smc_data[d] = '0;
            prev_oe[d] = 1'b0; tot_terr[d] = 0;
            clear_mon(d);
            for (int a = 0; a < 16; a++) ref_vld[d][a] = 1'b0;
        end
        n_sys_reset = 1'b0;
        step(); step(); step();
        for (int d = 0; d < 2; d++) begin
            check_eq("rst_state", resp_state[d], 0);
            check_eq("rst_oe", mem_data_oe[d], 0);
            check_eq("rst_mem_data", mem_data[d], 0);
            check_eq("rst_pulses", {rd_done[d], wr_done[d], timing_err[d]}, 0);
            check_eq("rst_err_count", err_count[d], 0);
        end
        n_sys_reset = 1'b1;
        step();

        // Initialise every location of both memories.
        for (int d = 0; d < 2; d++)
            for (int a = 0; a < 16; a++)
                do_write(d, a, wmin[d], 1'b0, '0, 1'b1);

        // Aborted read on the RD_LAT=3 instance: error, no drive, count 1.
        do_read(1, 7, 1);
        check_eq("abort_err_count_one", err_count[1], exp_errcnt(1));

        // Directed write/read of address 3 on the default instance.
        do_write(0, 3, 2, 1'b0, 32'hA5A5_0001, 1'b0);
        do_read(0, 3, 4);
        check_eq("dir_rd_data", rdat[0][0], 32'hA5A5_0001);

        // Back-to-back reads of 1 then 2.
        do_read2(0, 1, 2, 3, 4);

        // Too-short write on the WR_MIN=3 instance; old data must remain.
        do_write(1, 5, 1, 1'b0, 32'hDEAD_BEEF, 1'b0);
        do_read(1, 5, 5);

        // Randomised transaction mix.
        for (int t = 0; t < 160; t++) begin
            int d, k, a, a2;
            d = int'($urandom_range(1, 0));
            k = int'($urandom_range(6, 0));
            a = int'($urandom_range(15, 0));
            case (k)
                0, 1: do_write(d, a, int'($urandom_range(wmin[d] + 2, wmin[d])), 1'b0, '0, 1'b1);
                2:    do_write(d, a, int'($urandom_range(wmin[d] + 1, 1)), 1'b1, '0, 1'b1);
                3: begin
                    if (wmin[d] > 1) do_write(d, a, int'($urandom_range(wmin[d] - 1, 1)), 1'b0, '0, 1'b1);
                    else             do_conflict(d, int'($urandom_range(3, 1)));
                end
                4, 5: do_read(d, a, int'($urandom_range(lat[d] + 3, 1)));
                default: begin
                    a2 = (a + int'($urandom_range(15, 1))) % 16;
                    do_read2(d, a, a2, int'($urandom_range(lat[d] + 3, lat[d] + 1)),
                             int'($urandom_range(lat[d] + 3, lat[d] + 1)));
                end
            endcase
        end

        // Asynchronous reset while driving read data.
        clear_mon(0);
        smc_n_cs[0] = 1'b0; step();
        smc_addr[0] = 4'd9; smc_n_oe[0] = 1'b0; step();
        for (int i = 0; i < lat[0]; i++) step();
        check_eq("pre_rst_oe", mem_data_oe[0], 1);
        #2 n_sys_reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq("arst_oe", mem_data_oe[d], 0);
            check_eq("arst_state", resp_state[d], 0);
            check_eq("arst_mem_data", mem_data[d], 0);
            check_eq("arst_err_count", err_count[d], 0);
        end
        idle_bus(0);
        step();
        n_sys_reset = 1'b1;
        step();
        tot_terr[0] = 0; tot_terr[1] = 0;
        // Memory contents survive reset.
        do_read(0, 9, lat[0] + 2);
        do_read(1, 9, lat[1] + 1);

        // Error counter saturation.
        do_conflict(0, 300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/smc_mem_resp_lite.md
SMC_MEM_RESP_LITE -- requirements
Module: smc_mem_resp_lite

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, word-address width (memory depth 2**ADDR_W).
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter RD_LAT, default 2, cycles from OE-low sample to data drive (legal 1..15).
REQ-004 SHALL have parameter WR_MIN, default 1, minimum WE-low cycles for a write to commit (legal 1..15).
REQ-005 SHALL have port sys_clk, input, 1, system clock, rising edge.
REQ-006 SHALL have port n_sys_reset, input, 1, reset; one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port smc_n_cs, input, 1, chip select from controller, active low.
REQ-008 SHALL have port smc_n_oe, input, 1, read strobe, active low.
REQ-009 SHALL have port smc_n_we, input, 1, write strobe, active low.
REQ-010 SHALL have port smc_addr, input, ADDR_W, word address.
REQ-011 SHALL have port smc_data, input, DATA_W, write data from controller.
REQ-012 SHALL have port mem_data, output, DATA_W, read data toward controller.
REQ-013 SHALL have port mem_data_oe, output, 1, read data drive enable.
REQ-014 SHALL have ports rd_done, wr_done, timing_err, output, 1 each, single-cycle pulses.
REQ-015 SHALL have port resp_state, output, 3, registered current state.
REQ-016 SHALL have port err_count, output, 8, protocol error count.

Function
REQ-017 All strobe inputs SHALL be sampled on sys_clk rising edge; no combinational input-to-output path other than mem_data from the read register.
REQ-018 States SHALL be IDLE=0, SELECT=1, RD_WAIT=2, RD_DRIVE=3, WR_ACTIVE=4.
REQ-019 IDLE: smc_n_cs=0 -> SELECT; otherwise stay.
REQ-020 SELECT: n_cs=1 -> IDLE; n_oe=0 and n_we=0 -> timing_err, stay; n_oe=0 -> RD_WAIT, latch addr, load counter RD_LAT-1; n_we=0 -> WR_ACTIVE, latch addr, load counter WR_MIN-1.
REQ-021 RD_WAIT: counter decrements each cycle; counter 0 -> RD_DRIVE, mem_data loaded with mem[addr_q].
REQ-022 RD_WAIT: n_oe=1 or n_cs=1 before counter 0 -> timing_err, no drive, next SELECT (n_cs=0) or IDLE.
REQ-023 RD_DRIVE: mem_data_oe=1; n_oe=1 or n_cs=1 -> rd_done, next SELECT/IDLE; mem_data_oe SHALL be 0 from the following cycle.
REQ-024 RD_DRIVE: smc_addr != addr_q with n_oe=0, n_cs=0 -> back-to-back read: latch new addr, reload counter, RD_WAIT, mem_data_oe low, no rd_done.
REQ-025 WR_ACTIVE: smc_data captured every cycle; counter decrements to 0 and holds.
REQ-026 WR_ACTIVE: first cycle with n_we=1 or n_cs=1: counter 0 -> write last captured data to mem[addr_q], wr_done; counter non-zero -> write suppressed, timing_err. Next SELECT (n_cs=0) or IDLE.
REQ-027 WR_ACTIVE: n_oe=0 -> timing_err each such cycle; write proceeds.
REQ-028 Write-to-read of same address in consecutive accesses SHALL return the new data.
REQ-029 Memory contents SHALL NOT be reset.

Reset
REQ-030 On n_sys_reset=0: resp_state=IDLE, mem_data=0, mem_data_oe=0, all pulses 0, counters 0, err_count=0; pending write discarded; takes effect mid-access without clock.

Configuration
REQ-031 With SMC_RESP_ERRCNT_EN defined, err_count SHALL increment on each timing_err pulse, saturating at 255.
REQ-032 Without SMC_RESP_ERRCNT_EN, err_count SHALL be constant 0 and no counter logic synthesised; timing_err unaffected.

Verification
REQ-033 Write addr 3 data 0xA5A5_0001, WE low 2 cycles -> wr_done once; read addr 3 -> mem_data_oe high 2 cycles after OE-low sample, mem_data=0xA5A5_0001, rd_done on OE rise.
REQ-034 CS held low, reads addr 1 then 2 by address change under OE -> two RD_WAIT phases, oe drops between, one rd_done at end.
REQ-035 WR_MIN=3, WE low 1 cycle -> timing_err, no wr_done, subsequent read returns old data.
REQ-036 OE raised after 1 cycle with RD_LAT=3 -> timing_err, mem_data_oe never 1, err_count=1 (macro on) / 0 (macro off).
REQ-037 Assert n_sys_reset in RD_DRIVE -> mem_data_oe=0 and resp_state=IDLE immediately; 300 errors -> err_count=255.
